onehot_index_serializer: RTL and testbench
==========================================

// Module: onehot_index_serializer
// PURPOSE
//  Parametrised, clocked successor of the 8->3 one-hot encoder. Accepts a WIDTH-bit request
//  vector (one-hot or multi-hot) over a valid/ready handshake. Emits the index code of every
//  set bit, one per cycle, in priority order over a second valid/ready handshake.
//  Sits between event/flag sources and index-driven consumers (muxes, interrupt/ID logic).
//  Index numbering is fixed for all configurations: code = WIDTH-1-pos, so bit WIDTH-1 -> 0
//  and bit 0 -> WIDTH-1.
// PARAMETERS
//  WIDTH     8   request vector width, >= 2
//  PRIO_LSB  0   0: scan from bit WIDTH-1 downward; 1: scan from bit 0 upward
//  (local) IDXW = $clog2(WIDTH)   code width
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous reset, active-high
//  inp        in   WIDTH  request vector
//  in_valid   in   1      inp valid
//  in_ready   out  1      block can accept a vector
//  out        out  IDXW   index code of the current set bit
//  out_valid  out  1      out is valid
//  out_ready  in   1      consumer accepts out
//  zero       out  1      1-cycle pulse: an all-zero vector was accepted
// BEHAVIOUR
//  - Reset (async assert): state=IDLE, pend=0, out_valid=0, out=0, zero=0, in_ready=0 while rst=1.
//  - Reset mid-operation discards the pending vector; no partial codes are emitted afterwards.
//  - States: IDLE, DRAIN. pend = WIDTH-bit register holding the bits not yet emitted.
//  - IDLE: in_ready=1, out_valid=0.
//    - On in_valid&&in_ready with inp!=0: pend<=inp, go to DRAIN.
//    - On in_valid&&in_ready with inp==0: stay IDLE, zero=1 for the next cycle only.
//  - DRAIN: in_ready=0, out_valid=1.
//    - out = code of the highest-priority set bit in pend, taken from PRIO_LSB scan order.
//    - out is decoded from registered pend only; there is no combinational path from inp.
//    - On out_valid&&out_ready: clear that bit in pend.
//      - If it was the last set bit: go to IDLE.
//      - Otherwise stay in DRAIN; the next code appears the following cycle.
//    - out_ready=0: out and out_valid held stable, pend unchanged.
//  - Latency: first code valid 1 cycle after the accept edge.
//  - Throughput: 1 code/cycle. One IDLE cycle separates consecutive vectors.
//  - A vector with k set bits occupies DRAIN for k handshakes; an 8'hFF vector yields 0..7 in order.
//  - inp is ignored outside the accept cycle; changes during DRAIN have no effect.
// CONFIGURATION
//  OIS_LAST_EN defined:
//    - adds output port out_last (1 bit, reset 0).
//    - out_last=1 with out_valid when the current code is the final set bit of the vector.
//  OIS_LAST_EN undefined:
//    - port absent; all other behaviour identical.
// TESTING
//  1 rst pulse; inp=8'h08, in_valid 1 cycle, out_ready=1 -> next cycle out=3'b100, out_valid=1
//    (out_last=1); then IDLE, in_ready=1.
//  2 inp=8'b1000_0001, out_ready=1 -> out=0 then out=7 on consecutive cycles; out_valid low after.
//  3 inp=8'h24, out_ready=0 for 3 cycles -> out=2 held stable with out_valid=1; out_ready=1 ->
//    out=5, then IDLE.
//  4 inp=8'h00 accepted -> zero=1 for one cycle; out_valid stays 0; in_ready stays 1.
//  5 inp=8'hFF, rst asserted after 2 codes -> out_valid=0, in_ready=0 immediately;
//    after release in_ready=1, no stale codes.
//  6 WIDTH=16, PRIO_LSB=1, inp=16'h8001 -> out=15 then out=0.

Source files
------------

// File: rtl/onehot_index_serializer.sv
// Serialises a one-hot/multi-hot request vector into index codes, one per cycle, in priority order.
// Optional OIS_LAST_EN adds an out_last flag marking the final code of each vector.
module onehot_index_serializer #(
    parameter int WIDTH    = 8,
    parameter int PRIO_LSB = 0,
    localparam int IDXW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inp,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IDXW-1:0]  out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             zero
`ifdef OIS_LAST_EN
    ,
    output logic             out_last
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] pend;
    logic [WIDTH-1:0] pend_next;
    logic [WIDTH-1:0] sel_mask;
    logic [WIDTH-1:0] pend_left;
    logic [IDXW-1:0]  sel_code;
    logic             found;
    logic             accept;
    logic             zero_next;
    logic             ready_next;
    int               pos;

    // Priority pick over the registered pend only, so out never depends on inp.
    always_comb begin
        sel_mask = '0;
        sel_code = '0;
        found    = 1'b0;
        pos      = 0;
        for (int i = 0; i < WIDTH; i++) begin
            pos = (PRIO_LSB != 0) ? i : (WIDTH - 1 - i);
            if (!found && pend[pos]) begin
                found         = 1'b1;
                sel_mask[pos] = 1'b1;
                sel_code      = IDXW'(WIDTH - 1 - pos);
            end
        end
    end

    assign pend_left = pend & ~sel_mask;
    assign accept    = in_valid && in_ready && (state == IDLE);

    always_comb begin
        state_next = state;
        pend_next  = pend;
        zero_next  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (inp != '0) begin
                        pend_next  = inp;
                        state_next = DRAIN;
                    end else begin
                        zero_next = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    pend_next = pend_left;
                    if (pend_left == '0) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                pend_next  = '0;
            end
        endcase
        ready_next = (state_next == IDLE);
    end

    // in_ready is registered so it stays low for the whole reset and rises one edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pend     <= '0;
            zero     <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            state    <= state_next;
            pend     <= pend_next;
            zero     <= zero_next;
            in_ready <= ready_next;
        end
    end

    assign out       = sel_code;
    assign out_valid = (state == DRAIN);

`ifdef OIS_LAST_EN
    assign out_last = (state == DRAIN) && (pend_left == '0);
`endif

endmodule

// File: tb/tb_onehot_index_serializer.sv
// Directed self-checking bench for onehot_index_serializer (8-bit MSB-first and 16-bit LSB-first instances).
module tb_onehot_index_serializer;

    logic        clk;
    logic        rst;

    logic [7:0]  inp;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  out;
    logic        out_valid;
    logic        out_ready;
    logic        zero;

    logic [15:0] inp16;
    logic        in_valid16;
    logic        in_ready16;
    logic [3:0]  out16;
    logic        out_valid16;
    logic        out_ready16;
    logic        zero16;

`ifdef OIS_LAST_EN
    logic        out_last;
    logic        out_last16;
`endif

    int total;
    int bad;

    onehot_index_serializer #(.WIDTH(8), .PRIO_LSB(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .inp       (inp),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .zero      (zero)
`ifdef OIS_LAST_EN
        ,
        .out_last  (out_last)
`endif
    );

    onehot_index_serializer #(.WIDTH(16), .PRIO_LSB(1)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .inp       (inp16),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .out       (out16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .zero      (zero16)
`ifdef OIS_LAST_EN
        ,
        .out_last  (out_last16)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] v, input logic vld, input logic rdy);
        inp       = v;
        in_valid  = vld;
        out_ready = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        applyStimulus(8'h00, 1'b0, 1'b0);
        inp16       = '0;
        in_valid16  = 1'b0;
        out_ready16 = 1'b0;

        // Test 1: reset state, single one-hot bit
        step();
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out", out, 0);
        checkOutput("rst_zero", zero, 0);
        rst = 1'b0;
        step();
        checkOutput("t1_idle_ready", in_ready, 1);
        applyStimulus(8'h08, 1'b1, 1'b1);
        step();
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput("t1_out", out, 4);
        checkOutput("t1_valid", out_valid, 1);
        checkOutput("t1_in_ready_drain", in_ready, 0);
`ifdef OIS_LAST_EN
        checkOutput("t1_last", out_last, 1);
`endif
        step();
        checkOutput("t1_valid_after", out_valid, 0);
        checkOutput("t1_ready_after", in_ready, 1);

        // Test 2: two bits at both ends, MSB-first
        applyStimulus(8'b1000_0001, 1'b1, 1'b1);
        step();
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput("t2_out0", out, 0);
        checkOutput("t2_valid0", out_valid, 1);
`ifdef OIS_LAST_EN
        checkOutput("t2_last0", out_last, 0);
`endif
        step();
        checkOutput("t2_out1", out, 7);
        checkOutput("t2_valid1", out_valid, 1);
        step();
        checkOutput("t2_valid_end", out_valid, 0);

        // Test 3: backpressure holds the code; inp during DRAIN is ignored
        applyStimulus(8'h24, 1'b1, 1'b0);
        step();
        applyStimulus(8'hFF, 1'b1, 1'b0);
        checkOutput("t3_out_first", out, 2);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("t3_hold_out", out, 2);
            checkOutput("t3_hold_valid", out_valid, 1);
        end
        applyStimulus(8'h00, 1'b0, 1'b1);
        step();
        checkOutput("t3_out_second", out, 5);
`ifdef OIS_LAST_EN
        checkOutput("t3_last", out_last, 1);
`endif
        step();
        checkOutput("t3_valid_end", out_valid, 0);
        checkOutput("t3_ready_end", in_ready, 1);

        // Test 4: all-zero vector
        applyStimulus(8'h00, 1'b1, 1'b1);
        step();
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput("t4_zero_pulse", zero, 1);
        checkOutput("t4_valid", out_valid, 0);
        checkOutput("t4_ready", in_ready, 1);
        step();
        checkOutput("t4_zero_drop", zero, 0);
        checkOutput("t4_valid_after", out_valid, 0);

        // Test 5: reset mid-drain of 8'hFF
        applyStimulus(8'hFF, 1'b1, 1'b1);
        step();
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput("t5_code0", out, 0);
        step();
        checkOutput("t5_code1", out, 1);
        step();
        checkOutput("t5_code2", out, 2);
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_valid", out_valid, 0);
        checkOutput("t5_rst_ready", in_ready, 0);
        checkOutput("t5_rst_out", out, 0);
        step();
        rst = 1'b0;
        step();
        checkOutput("t5_ready_after", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("t5_no_stale", out_valid, 0);
        end

        // Test 6: 16-bit LSB-first instance
        inp16       = 16'h8001;
        in_valid16  = 1'b1;
        out_ready16 = 1'b1;
        step();
        in_valid16  = 1'b0;
        inp16       = '0;
        checkOutput("t6_out0", out16, 15);
        checkOutput("t6_valid0", out_valid16, 1);
        step();
        checkOutput("t6_out1", out16, 0);
        checkOutput("t6_valid1", out_valid16, 1);
`ifdef OIS_LAST_EN
        checkOutput("t6_last", out_last16, 1);
`endif
        step();
        checkOutput("t6_valid_end", out_valid16, 0);
        checkOutput("t6_ready_end", in_ready16, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
